// File: rtl/aes_key_schedule.sv
// aes_key_schedule -- sequential AES-128 key expansion, one round per clock.
//
// A cipher key is accepted on key_valid & key_ready. Round keys 1..10 are then
// computed on the next ten edges and written into an 11-slot register file
// (slot 0 = cipher key). The cipher datapath reads any slot by index.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   key_valid, key_in   cipher key offer; w0 = key_in[127:96], w3 = key_in[31:0]
//   key_ready           engine can take a key (idle or finished)
//   busy                expansion in progress
//   keys_valid          slots 0..10 belong to the last accepted key
//   done                one-cycle pulse when round 10 has been written
//   rd_round, rd_key    round-key read port; slots above 10 read as zero
//
// Build option: RDKEY_REG_OUT_EN -- when defined, rd_key is registered (one
// cycle read latency, resets to 0); otherwise rd_key is a combinational mux.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  localparam logic [7:0] TBL [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  assign s_o = TBL[a_i];
endmodule

module aes_key_schedule #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [127:0]        work_q, work_d;
  logic [10:0][127:0]  slots_q, slots_d;
  logic                kv_q, kv_d, done_q, done_d;

  logic [31:0]         w3;
  logic [3:0][7:0]     sb_in, sb_out;
  logic [7:0]          rcon;
  logic [31:0]         t, w0n, w1n, w2n, w3n;
  logic [127:0]        rk;

  // RotWord folded into the S-box input order: lane 3 (MSB) takes w3 byte 2.
  assign w3    = work_q[31:0];
  assign sb_in = {w3[23:16], w3[15:8], w3[7:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a_i(sb_in[g]), .s_o(sb_out[g]));
  end

  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t   = sb_out ^ {rcon, 24'h0};
  assign w0n = work_q[127:96] ^ t;
  assign w1n = work_q[95:64]  ^ w0n;
  assign w2n = work_q[63:32]  ^ w1n;
  assign w3n = work_q[31:0]   ^ w2n;
  assign rk  = {w0n, w1n, w2n, w3n};

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = kv_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    slots_d = slots_q;
    kv_d    = kv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          slots_d[0] = key_in;
          work_d     = key_in;
          cnt_d      = 4'd1;
          kv_d       = 1'b0;
          state_d    = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i <= NR; i++)
          if (cnt_q == 4'(i)) slots_d[i] = rk;
        work_d = rk;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          state_d = DONE;
          kv_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      slots_q <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      slots_q <= slots_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
    end
  end

  // Slot read mux; indices 11..15 fall through to zero.
  logic [127:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NR; i++)
      if (rd_round == 4'(i)) rd_mux = slots_q[i];
  end

`ifdef RDKEY_REG_OUT_EN
  logic [127:0] rd_key_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_key_q <= '0;
    else        rd_key_q <= rd_mux;
  end
  assign rd_key = rd_key_q;
`else
  assign rd_key = rd_mux;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: random and known-answer keys checked against a
// word-oriented key-expansion model with an S-box computed from GF(2^8).
module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready, busy, keys_valid, done;
  logic [3:0]   rd_round = '0;
  logic [127:0] rd_key;

  int n_chk = 0;
  int n_pass = 0;

  typedef logic [10:0][127:0] rk_t;

  aes_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid), .done(done),
    .rd_round(rd_round), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[6:0], x[7]};
    return x;
  endfunction

  // S(x) = affine(x^-1), with 0 mapping through inverse 0.
  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int r);
    logic [7:0] c = 8'h01;
    for (int i = 1; i < r; i++) c = xt(c);
    return c;
  endfunction

  function automatic rk_t expand_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    rk_t rks;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])}
              ^ {rcon_ref(i/4), 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  // ---------------- drivers ----------------
  task automatic read_slot(input logic [3:0] idx, output logic [127:0] v);
    rd_round = idx;
`ifdef RDKEY_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    v = rd_key;
  endtask

  task automatic check_slots(input string tag, input rk_t exp);
    logic [127:0] v;
    for (int r = 0; r < 11; r++) begin
      read_slot(4'(r), v);
      chk($sformatf("%s slot%0d", tag, r), v, exp[r]);
    end
  endtask

  // Accept key, optionally hold key_valid with another key during expansion,
  // then check latency, done pulse count and every slot.
  task automatic run_key(input string tag, input logic [127:0] key, input bit jam);
    int lat = 0;
    int dones = 0;
    @(negedge clk);
    key_valid = 1'b1;
    key_in = key;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " busy@T0"}, 128'(busy), 128'd1);
    chk({tag, " kv@T0"}, 128'(keys_valid), 128'd0);
    if (jam) key_in = key ^ {4{$urandom}} ^ 128'h1;
    else key_valid = 1'b0;
    while (!keys_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (done) dones++;
      if (lat == 3) chk({tag, " ready mid"}, 128'(key_ready), 128'd0);
      if (keys_valid) key_valid = 1'b0;
    end
    key_valid = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'd10);
    @(posedge clk);
    @(negedge clk);
    if (done) dones++;
    chk({tag, " done pulses"}, 128'(dones), 128'd1);
    chk({tag, " ready@done"}, 128'(key_ready), 128'd1);
    check_slots(tag, expand_ref(key));
  endtask

  initial begin
    logic [127:0] v, k;
    rk_t exp;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst key_ready", 128'(key_ready), 128'd1);
    chk("rst busy", 128'(busy), 128'd0);
    chk("rst keys_valid", 128'(keys_valid), 128'd0);
    chk("rst done", 128'(done), 128'd0);
    chk("rst rd_key", rd_key, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_slot(4'd3, v);
    chk("rst slot3", v, 128'h0);

    // FIPS-197 key, with a competing key held during expansion
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_key("fips", k, 1'b1);
    read_slot(4'd1, v);
    chk("fips kat slot1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_slot(4'd10, v);
    chk("fips kat slot10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // back-to-back: all-zero key accepted from DONE
    run_key("zero", 128'h0, 1'b0);
    read_slot(4'd10, v);
    chk("zero kat slot10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // out-of-range reads
    for (int r = 11; r < 16; r++) begin
      read_slot(4'(r), v);
      chk($sformatf("oob rd%0d", r), v, 128'h0);
    end

    // random keys
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_key($sformatf("rnd%0d", n), k, n[0]);
    end

    // reset in the middle of an expansion
    @(negedge clk);
    key_valid = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-abort busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 128'(busy), 128'd0);
    chk("abort keys_valid", 128'(keys_valid), 128'd0);
    chk("abort key_ready", 128'(key_ready), 128'd1);
    chk("abort done", 128'(done), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp = '0;
    check_slots("abort", exp);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_key("post-abort", k, 1'b0);

`ifdef RDKEY_REG_OUT_EN
    // registered read: output follows rd_round only after the next edge
    @(negedge clk);
    exp = expand_ref(k);
    rd_round = 4'd2;
    @(posedge clk);
    @(negedge clk);
    rd_round = 4'd7;
    #1;
    chk("reg rd hold", rd_key, exp[2]);
    @(posedge clk);
    #1;
    chk("reg rd update", rd_key, exp[7]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
